// File: rtl/display_scan_mux.sv
// display_scan_mux: time-multiplexed 4-digit scanner with blanking gaps, frame-synchronous update and leading-zero suppression
module display_scan_mux #(
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] value,
    input  logic        lzs,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic [3:0]  digit_en,
    output logic        frame_done,
    output logic        pending
);
    typedef enum logic {GAP, SHOW} state_t;
    localparam logic [15:0] SHOW_LAST = 16'(SCAN_DIV - 1);
    localparam logic [15:0] GAP_LAST  = 16'(BLANK_CYCLES - 1);
    state_t      state, state_n;
    logic [15:0] cnt, cnt_n, active, active_n, staging;
    logic [1:0]  idx, idx_n;
    logic [3:0]  nib;
    logic        last, boundary, blank_n;
    always_comb begin
        last     = cnt == (state == SHOW ? SHOW_LAST : GAP_LAST);
        boundary = state == SHOW && idx == 2'd3 && last;
        state_n  = last ? (state == GAP ? SHOW : GAP) : state;
        cnt_n    = last ? 16'd0 : cnt + 16'd1;
        idx_n    = state == SHOW && last ? idx + 2'd1 : idx;
        active_n = !boundary ? active : load ? value : pending ? staging : active;
        blank_n  = lzs && idx_n != 2'd0 && (active_n >> {idx_n, 2'b00}) == 16'd0;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= GAP;
            cnt        <= 16'd0;
            idx        <= 2'd0;
            active     <= 16'd0;
            staging    <= 16'd0;
            pending    <= 1'b0;
            nib        <= 4'd0;
            digit_en   <= 4'hF;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            active     <= active_n;
            staging    <= load ? value : staging;
            pending    <= !boundary && (load || pending);
            nib        <= active_n[{idx_n, 2'b00} +: 4];
            digit_en   <= state_n == SHOW && !blank_n ? ~(4'b0001 << idx_n) : 4'hF;
            frame_done <= state_n == SHOW && idx_n == 2'd3 && cnt_n == SHOW_LAST;
        end
    end
    assign {a, b, c, d} = nib;
endmodule

// File: doc/display_scan_mux.md
DISPLAY_SCAN_MUX -- requirements
Module: display_scan_mux

Interface
REQ-001 Parameter: SCAN_DIV, default 1000, number of clock cycles each digit is lit (SHOW phase); legal range 2..65535.
REQ-002 Parameter: BLANK_CYCLES, default 16, number of all-off cycles before each digit (GAP phase); legal range 1..255.
REQ-003 Port: clk  input  1  single clock; all logic on its rising edge.
REQ-004 Port: rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 Port: load  input  1  one-cycle strobe; captures value into the staging register.
REQ-006 Port: value  input  16  four packed nibbles; digit 0 is value[3:0] (rightmost), digit 3 is value[15:12].
REQ-007 Port: lzs  input  1  leading-zero suppression enable; sampled every cycle.
REQ-008 Port: a, b, c, d  output  1 each  nibble of the digit being scanned, {a,b,c,d} = nibble[3:0], a = MSB; feeds the downstream 7-segment decoder.
REQ-009 Port: digit_en  output  4  active-low digit enables; bit i drives digit i.
REQ-010 Port: frame_done  output  1  one-cycle pulse at the end of digit 3 SHOW.
REQ-011 Port: pending  output  1  high while the staging register holds a value not yet shown.

Function
REQ-012 The FSM SHALL have exactly two states: GAP and SHOW. A phase counter SHALL count cycles within the current state.
REQ-013 GAP SHALL last BLANK_CYCLES cycles with digit_en = 4'b1111. During GAP, {a,b,c,d} SHALL already equal the nibble of the upcoming digit. After the last GAP cycle the FSM SHALL enter SHOW with the counter cleared.
REQ-014 SHOW SHALL last SCAN_DIV cycles with digit_en[digit_idx] = 0 and all other bits = 1, unless the digit is suppressed (REQ-017). After the last SHOW cycle, digit_idx SHALL increment and the FSM SHALL enter GAP.
REQ-015 digit_idx SHALL be 2 bits and wrap 3 -> 0. One full frame SHALL be 4*(SCAN_DIV+BLANK_CYCLES) cycles.
REQ-016 {a,b,c,d} SHALL be registered outputs taken from the active register at the current digit_idx. The active register is distinct from the staging register.
REQ-017 Suppression rule: when lzs = 1, digit i (i = 1..3) SHALL be blanked (digit_en[i] held at 1 during its SHOW) if active nibbles i through 3 are all zero. Digit 0 SHALL never be blanked. Timing is unchanged by suppression.
REQ-018 load = 1 SHALL write value into staging and set pending = 1 on the next edge. A later load before transfer SHALL overwrite staging, with last-writer-wins.
REQ-019 Frame boundary = the last SHOW cycle of digit 3. On that edge, frame_done SHALL pulse high for exactly one cycle. If pending = 1, the active register SHALL take staging and pending SHALL clear. The active register SHALL never change at any other time, so there is no tearing within a frame.
REQ-020 If load = 1 coincides with a frame boundary, the active register SHALL take the incoming value directly and pending SHALL be 0 after the edge.
REQ-021 If load = 0 at a frame boundary and pending = 0, the active register SHALL be unchanged and frame_done SHALL still pulse.
REQ-022 No combinational path SHALL exist from any input to any output.

Reset
REQ-023 While rst_n = 0 at an edge, the block SHALL set:
- state = GAP, phase counter = 0, digit_idx = 0
- active = 0, staging = 0, pending = 0
- digit_en = 4'b1111, {a,b,c,d} = 4'b0000, frame_done = 0
REQ-024 Reset asserted mid-SHOW or mid-frame SHALL abort the scan and discard staged data. The first cycle after rst_n rises SHALL be GAP cycle 0 for digit 0.

Verification (SCAN_DIV = 4, BLANK_CYCLES = 2; frame = 24 cycles)
REQ-025 Reset, then idle 48 cycles -> each digit is off for 2 cycles and on for 4; digit_en walks 1110, 1101, 1011, 0111 separated by 1111; {a,b,c,d} = 0000 throughout; frame_done pulses at cycles 23 and 47 after reset release.
REQ-026 load with value = 16'h1A3F in cycle 5 -> pending = 1 from cycle 6 to cycle 23; the first frame still shows 0000; the second frame shows nibbles F, 3, A, 1 on digits 0..3; pending = 0 from cycle 24.
REQ-027 load 16'h1111 then load 16'h2222 in the same frame -> the next frame shows only 2 on all digits, with no frame showing 1.
REQ-028 load 16'h00C0 coincident with a frame boundary, lzs = 1 -> the next frame shows digit 0 = 0 (lit) and digit 1 = C (lit); digits 2 and 3 keep digit_en bits at 1 during their SHOW; pending stays 0. With lzs = 0, all four digits are lit.
REQ-029 Active value 16'h0000 with lzs = 1 -> only digit 0 is lit, showing 0000.
REQ-030 rst_n pulsed low during digit 2 SHOW with pending = 1 -> outputs return to reset values; pending = 0; the scan restarts at digit 0 GAP; the staged value is never displayed.
